uart_loader: RTL and testbench
==============================

# uart_loader

Program loader sitting directly downstream of the `uart` receiver and alongside its transmitter in the MIPS debug path. It consumes received bytes, assembles 32-bit instruction words MSB-first, writes them sequentially into instruction memory from address 0, stops on the HALT word or memory full, and answers the host with a one-byte ACK/NAK through the UART transmitter. The loader replaces the rx→tx loopback once a program-load path is needed.

## Interface
- `NBITS`, 8, UART byte width
- `WORD_BITS`, 32, instruction width; must equal 4·`NBITS`
- `ADDR_BITS`, 10, instruction-memory word-address width
- `TIMEOUT_CYCLES`, 30000000, inter-byte timeout in clocks (used only with `UART_LOADER_TIMEOUT_EN`)

- `CLK_100MHZ` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high
- `rx_done_tick` in 1: one-cycle strobe, `rx_data` valid
- `rx_data` in NBITS: byte from UART receiver
- `tx_done_tick` in 1: one-cycle strobe, transmitter finished
- `tx_start` out 1: one-cycle pulse requesting a transmission
- `tx_data` out NBITS: byte to transmit, held stable until `tx_done_tick`
- `mem_we` out 1: one-cycle write strobe
- `mem_addr` out ADDR_BITS: word address
- `mem_wdata` out WORD_BITS: assembled word
- `busy` out 1: high in every state except IDLE and DONE
- `load_done` out 1: high in DONE
- `overflow` out 1: sticky, set when memory filled without HALT; cleared only by reset or a new load command

## Operation
- Constants: CMD_LOAD=0x01, ACK=0x06, NAK=0x15, HALT_WORD=0xFFFFFFFF.
- States: IDLE, RECV, WRITE, SEND, WAIT_TX, DONE.
- IDLE/DONE: on `rx_done_tick` with `rx_data`==CMD_LOAD → RECV; address, byte counter and `overflow` cleared. Any other byte is ignored.
- RECV: each `rx_done_tick` shifts the byte in (first byte → bits [31:24]) and increments the 2-bit byte counter; the 4th byte → WRITE.
- WRITE (one cycle): `mem_we`=1 with current address and word. Then:
  - word==HALT_WORD → SEND with ACK (HALT word is written);
  - else address==2^ADDR_BITS−1 → set `overflow`, SEND with NAK;
  - else address+1 → RECV.
- SEND (one cycle): `tx_start`=1 → WAIT_TX. WAIT_TX: on `tx_done_tick` → DONE if ACK was sent, IDLE if NAK was sent.
- `rx_done_tick` in WRITE, SEND or WAIT_TX is dropped.
- Reset mid-load: all state is discarded and memory contents are left as written. There is no rollback.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `load_done`=0, `overflow`=0; state=IDLE.
- 4th byte strobe at cycle t → `mem_we` high at t+1. Next `mem_addr` is visible at t+2.
- ACK/NAK: `tx_start` pulses at t+2 after the final WRITE strobe.
- Address wraps never: full memory terminates the load.
- `tx_data` is registered and changes only when entering SEND.

## Configuration
- `UART_LOADER_TIMEOUT_EN` defined:
  - A counter runs in RECV and is cleared on every `rx_done_tick`.
  - Reaching `TIMEOUT_CYCLES` discards the partial word and transmits NAK, which returns the loader to IDLE.
  - `overflow` is unaffected.
- Undefined: no counter is synthesized, and RECV waits indefinitely.

## Structure
- Shared package/header `uart_loader_pkg`: state encoding, CMD_LOAD, ACK, NAK, HALT_WORD.
- One sub-module `uart_word_assembler`: byte shift register plus byte counter, with a `word_valid` pulse output.
- The FSM, address counter and TX handshake live in `uart_loader`.

## Test plan
- Send 0x01, then bytes 12 34 56 78, then FF FF FF FF → `mem_we` pulses twice: addr 0 gets 0x12345678, addr 1 gets 0xFFFFFFFF. `tx_data`=0x06 is sent, then `load_done`=1 and `overflow`=0.
- Send byte 0x55 in IDLE → no state change, no `tx_start`.
- With `ADDR_BITS`=2: send 0x01, then four non-HALT words → 4 writes to addr 0..3, `overflow`=1, NAK 0x15 sent, state returns to IDLE.
- Send 0x01 and two bytes, assert `reset` → all outputs return to reset values. A new 0x01 plus a word writes that word at addr 0.
- `rx_done_tick` during WAIT_TX → byte dropped, no `mem_we`. DONE is reached after `tx_done_tick`.
- With `UART_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send 0x01 and 3 bytes, then go idle for 100 cycles → NAK sent, no write, state returns to IDLE.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared constants and state encoding for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    WRITE   = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [7:0]  CMD_LOAD  = 8'h01;
  localparam logic [7:0]  ACK       = 8'h06;
  localparam logic [7:0]  NAK       = 8'h15;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_word_assembler.sv
// Shifts received bytes MSB-first into a word; word_valid pulses the cycle
// after the byte that completes the word.
module uart_word_assembler #(
  parameter int unsigned NBITS     = 8,
  parameter int unsigned WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [NBITS-1:0]     data,
  output logic [WORD_BITS-1:0] word,
  output logic [1:0]           count,
  output logic                 word_valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word       <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (shift_en) begin
        word       <= {word[WORD_BITS-NBITS-1:0], data};
        count      <= count + 2'd1;
        word_valid <= (count == 2'd3);
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART program loader: assembles words, writes instruction memory, replies ACK/NAK.
// Optional inter-byte timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned NBITS          = 8,
  parameter int unsigned WORD_BITS      = 32,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 30000000
) (
  input  logic                 CLK_100MHZ,
  input  logic                 reset,
  input  logic                 rx_done_tick,
  input  logic [NBITS-1:0]     rx_data,
  input  logic                 tx_done_tick,
  output logic                 tx_start,
  output logic [NBITS-1:0]     tx_data,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_BITS-1:0] mem_wdata,
  output logic                 busy,
  output logic                 load_done,
  output logic                 overflow
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  if (WORD_BITS != 4 * NBITS || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("uart_loader: WORD_BITS must be 4*NBITS and TIMEOUT_CYCLES nonzero");
  end

  state_t     state;
  logic       sent_ack;
  logic [1:0] byte_count;
  logic       start_load;
  logic       shift_en;
  logic       timeout;

  assign start_load = rx_done_tick && (rx_data == NBITS'(CMD_LOAD)) &&
                      (state == IDLE || state == DONE);
  assign shift_en   = rx_done_tick && (state == RECV);

  uart_word_assembler #(
    .NBITS     (NBITS),
    .WORD_BITS (WORD_BITS)
  ) u_assembler (
    .clk        (CLK_100MHZ),
    .reset      (reset),
    .clear      (start_load),
    .shift_en   (shift_en),
    .data       (rx_data),
    .word       (mem_wdata),
    .count      (byte_count),
    .word_valid (mem_we)
  );

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Counts RECV cycles since the last received byte.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state != RECV || rx_done_tick) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign timeout = (state == RECV) && !rx_done_tick &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
      sent_ack  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_load) begin
            state     <= RECV;
            mem_addr  <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            load_done <= 1'b0;
          end
        end
        RECV: begin
          if (shift_en && byte_count == 2'd3) begin
            state <= WRITE;
          end else if (timeout) begin
            state    <= SEND;
            tx_start <= 1'b1;
            tx_data  <= NBITS'(NAK);
            sent_ack <= 1'b0;
          end
        end
        // mem_we is high this cycle; decide how the load continues.
        WRITE: begin
          if (mem_wdata == WORD_BITS'(HALT_WORD)) begin
            state    <= SEND;
            tx_start <= 1'b1;
            tx_data  <= NBITS'(ACK);
            sent_ack <= 1'b1;
          end else if (mem_addr == LAST_ADDR) begin
            state    <= SEND;
            tx_start <= 1'b1;
            tx_data  <= NBITS'(NAK);
            sent_ack <= 1'b0;
            overflow <= 1'b1;
          end else begin
            state    <= RECV;
            mem_addr <= mem_addr + ADDR_BITS'(1);
          end
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done_tick) begin
            state     <= sent_ack ? DONE : IDLE;
            busy      <= 1'b0;
            load_done <= sent_ack;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized self-checking bench for uart_loader against a host-level model.
// Adds the inter-byte timeout scenario when UART_LOADER_TIMEOUT_EN is defined.
module tb_uart_loader;

  localparam int unsigned AB    = 2;
  localparam int unsigned DEPTH = 1 << AB;
  localparam logic [7:0]  C_ACK = 8'h06;
  localparam logic [7:0]  C_NAK = 8'h15;

  typedef struct {
    logic [AB-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_done_tick;
  logic [7:0]    rx_data;
  logic          tx_done_tick;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          load_done;
  logic          overflow;

  uart_loader #(
    .NBITS(8), .WORD_BITS(32), .ADDR_BITS(AB), .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK_100MHZ   (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .load_done    (load_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Host-level model: mode 0 idle, 1 done, 2 receiving, 3 awaiting reply.
  int         m_mode = 0;
  int         m_addr = 0;
  int         m_cnt  = 0;
  logic [31:0] m_word = '0;
  bit         m_busy = 0, m_done = 0, m_ovf = 0;
  logic [7:0] m_txd  = '0;
  logic [7:0] m_resp = '0;
  bit         m_resp_ovf = 0;

  wr_t        exp_wr[$];
  wr_t        got_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model and expected event queues.
  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_we) begin
        check("write_expected", 64'(exp_wr.size() != 0), 64'd1);
        got_wr.push_back('{mem_addr, mem_wdata});
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(e.a));
          check("mem_wdata", 64'(mem_wdata), 64'(e.d));
        end
      end
      if (tx_start) begin
        check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        got_tx.push_back(tx_data);
        if (exp_tx.size() != 0) check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
      check("busy", 64'(busy), 64'(m_busy));
      check("load_done", 64'(load_done), 64'(m_done));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("tx_data_held", 64'(tx_data), 64'(m_txd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_mode == 0 || m_mode == 1) begin
      if (b == 8'h01) begin
        m_mode = 2; m_addr = 0; m_cnt = 0; m_ovf = 0; m_busy = 1; m_done = 0;
      end
    end else if (m_mode == 2) begin
      m_word = {m_word[23:0], b};
      m_cnt++;
      if (m_cnt == 4) begin
        m_cnt = 0;
        exp_wr.push_back('{AB'(m_addr), m_word});
        if (m_word == 32'hFFFF_FFFF) begin
          m_mode = 3; m_resp = C_ACK; m_resp_ovf = 0;
        end else if (m_addr == DEPTH - 1) begin
          m_mode = 3; m_resp = C_NAK; m_resp_ovf = 1;
        end else begin
          m_addr++;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit modeled);
    rx_data = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    if (modeled) model_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8], 1'b1);
      if (m_mode != 2) break;
      idle($urandom_range(1, 3));
    end
  endtask

  // Wait for the ACK/NAK pulse, optionally poke a byte during WAIT_TX, then complete TX.
  task automatic finish_tx(input int lat_lo, input int lat_hi, input bit drop);
    int n;
    n = 0;
    exp_tx.push_back(m_resp);
    while (!tx_start && n < 300) begin
      tick();
      n++;
    end
    check("tx_start_latency", 64'(n >= lat_lo && n <= lat_hi), 64'd1);
    m_txd = m_resp;
    if (m_resp_ovf) m_ovf = 1;
    idle($urandom_range(1, 3));
    if (drop) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      idle($urandom_range(0, 2));
    end
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    m_busy = 0;
    m_done = (m_resp == C_ACK);
    m_mode = (m_resp == C_ACK) ? 1 : 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_mode = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_txd = '0; m_cnt = 0;
    #1;
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] b;
    logic [31:0] w;
    reset = 1'b1;
    rx_done_tick = 1'b0;
    rx_data = '0;
    tx_done_tick = 1'b0;
    tick();
    apply_reset();
    chk_en = 1;

    // Basic load: one word then HALT.
    send_byte(8'h01, 1'b1);
    idle(2);
    base = got_wr.size();
    for (int k = 0; k < 4; k++) begin
      b = 8'h12 + 8'(k * 8'h22);
      send_byte(b, 1'b1);
      idle(1);
    end
    send_word(32'hFFFF_FFFF);
    check("we_after_4th_byte", 64'(mem_we), 64'd1);
    finish_tx(1, 1, 1'b1);
    idle(2);
    check("lit_wr0_addr", 64'(got_wr[base].a), 64'd0);
    check("lit_wr0_data", 64'(got_wr[base].d), 64'h1234_5678);
    check("lit_wr1_addr", 64'(got_wr[base+1].a), 64'd1);
    check("lit_wr1_data", 64'(got_wr[base+1].d), 64'hFFFF_FFFF);
    check("lit_ack", 64'(got_tx[got_tx.size()-1]), 64'h06);
    check("lit_load_done", 64'(load_done), 64'd1);
    check("lit_overflow0", 64'(overflow), 64'd0);

    // Non-command byte while DONE is ignored.
    send_byte(8'h55, 1'b1);
    idle(3);
    check("lit_ignore_busy", 64'(busy), 64'd0);
    check("lit_ignore_done", 64'(load_done), 64'd1);

    // Fill all of memory without HALT.
    send_byte(8'h01, 1'b1);
    idle(1);
    base = got_wr.size();
    for (int i = 0; i < DEPTH; i++) send_word(32'hA000_0000 + 32'(i));
    finish_tx(1, 1, 1'b0);
    idle(2);
    check("lit_ovf_writes", 64'(got_wr.size() - base), 64'(DEPTH));
    check("lit_ovf_last_addr", 64'(got_wr[got_wr.size()-1].a), 64'(DEPTH - 1));
    check("lit_nak", 64'(got_tx[got_tx.size()-1]), 64'h15);
    check("lit_overflow1", 64'(overflow), 64'd1);
    check("lit_ovf_idle", 64'(load_done), 64'd0);

    // Reset mid-word, then a fresh load lands at address 0.
    send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    idle(1);
    apply_reset();
    send_byte(8'h01, 1'b1);
    base = got_wr.size();
    send_word(32'hA5A5_0001);
    check("lit_post_rst_addr", 64'(got_wr[base].a), 64'd0);
    check("lit_post_rst_data", 64'(got_wr[base].d), 64'hA5A5_0001);
    send_word(32'hFFFF_FFFF);
    finish_tx(1, 1, 1'b1);

`ifdef UART_LOADER_TIMEOUT_EN
    // Stalled partial word times out with NAK and no write.
    send_byte(8'h01, 1'b1);
    base = got_wr.size();
    for (int k = 0; k < 3; k++) send_byte(8'h40 + 8'(k), 1'b1);
    m_mode = 3; m_resp = C_NAK; m_resp_ovf = 0; m_cnt = 0;
    finish_tx(100, 101, 1'b0);
    check("lit_timeout_nowrite", 64'(got_wr.size() - base), 64'd0);
    check("lit_timeout_nak", 64'(got_tx[got_tx.size()-1]), 64'h15);
`endif

    // Randomized loads.
    for (int l = 0; l < 25; l++) begin
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h01) b = 8'h02;
        send_byte(b, 1'b1);
        idle($urandom_range(0, 2));
      end
      send_byte(8'h01, 1'b1);
      idle($urandom_range(0, 3));
      while (m_mode == 2) begin
        w = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        send_word(w);
        if (m_mode == 2 && $urandom_range(0, 15) == 0) apply_reset();
      end
      if (m_mode == 3) finish_tx(1, 1, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 4));
    end

    idle(3);
    check("write_queue_drained", 64'(exp_wr.size()), 64'd0);
    check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
